// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory side of dmem_arbiter.
// slave: the arbiter's view; master: the requesters, the memory model and the bench.
interface dmem_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    // port 0: pipeline MEM stage
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_err;

    // port 1: memory loader / DMA
    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_err;

    // single-ported data memory
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  read_data,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_read, mem_write, address, write_data
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output read_data,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_read, mem_write, address, write_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Fixed-priority two-port data-memory arbiter with an anti-starvation wait counter
// for port 1 and registered, per-port read responses.
module dmem_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("dmem_arbiter: MAX_WAIT must lie in 1..15");
    end

    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_nxt;
    logic              forced_c;
    logic              p0_gnt_c;
    logic              p1_gnt_c;
    logic              p0_in_range;
    logic              p1_in_range;

    logic              p0_rvalid_q;
    logic [DATA_W-1:0] p0_rdata_q;
    logic              p0_err_q;
    logic              p1_rvalid_q;
    logic [DATA_W-1:0] p1_rdata_q;
    logic              p1_err_q;

    assign p0_in_range = (bus.p0_addr < ADDR_W'(DEPTH));
    assign p1_in_range = (bus.p1_addr < ADDR_W'(DEPTH));
    assign forced_c    = (wait_cnt == WAIT_LIMIT);

    // wait counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // wait counter next state: clears on grant or abandon, saturates at the limit
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (!bus.p1_req || p1_gnt_c) begin
            wait_cnt_nxt = '0;
        end else if (wait_cnt < WAIT_LIMIT) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
    end

    // grant selection; priority flips to port 1 only while forced
    always_comb begin
        p0_gnt_c = 1'b0;
        p1_gnt_c = 1'b0;
        if (forced_c) begin
            p1_gnt_c = bus.p1_req;
            p0_gnt_c = bus.p0_req && !bus.p1_req;
        end else begin
            p0_gnt_c = bus.p0_req;
            p1_gnt_c = bus.p1_req && !bus.p0_req;
        end
    end

    // memory drive for the winner; out-of-range accesses never strobe the memory
    always_comb begin
        bus.p0_gnt     = p0_gnt_c;
        bus.p1_gnt     = p1_gnt_c;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;
        if (p0_gnt_c) begin
            bus.address    = bus.p0_addr;
            bus.write_data = bus.p0_wdata;
            bus.mem_write  = bus.p0_we && p0_in_range;
            bus.mem_read   = !bus.p0_we && p0_in_range;
        end else if (p1_gnt_c) begin
            bus.address    = bus.p1_addr;
            bus.write_data = bus.p1_wdata;
            bus.mem_write  = bus.p1_we && p1_in_range;
            bus.mem_read   = !bus.p1_we && p1_in_range;
        end
    end

    // port 0 response registers; rdata holds between reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p0_err_q    <= 1'b0;
        end else begin
            p0_rvalid_q <= p0_gnt_c && !bus.p0_we;
            p0_err_q    <= p0_gnt_c && !p0_in_range;
            if (p0_gnt_c && !bus.p0_we) begin
                p0_rdata_q <= p0_in_range ? bus.read_data : '0;
            end
        end
    end

    // port 1 response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_rvalid_q <= 1'b0;
            p1_rdata_q  <= '0;
            p1_err_q    <= 1'b0;
        end else begin
            p1_rvalid_q <= p1_gnt_c && !bus.p1_we;
            p1_err_q    <= p1_gnt_c && !p1_in_range;
            if (p1_gnt_c && !bus.p1_we) begin
                p1_rdata_q <= p1_in_range ? bus.read_data : '0;
            end
        end
    end

    assign bus.p0_rvalid = p0_rvalid_q;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p0_err    = p0_err_q;
    assign bus.p1_rvalid = p1_rvalid_q;
    assign bus.p1_rdata  = p1_rdata_q;
    assign bus.p1_err    = p1_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle behaviour plus
// hand sequences for contention, abandonment, forced-drop and mid-operation reset.
module tb_dmem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int NV = 11;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1024), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // memory model: word i preloaded with i, combinational read, write on the edge
    logic [31:0] mem [0:1023];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'(i);
            mem_init <= 1'b1;
        end else if (bus.mem_write) begin
            mem[bus.address[9:0]] <= bus.write_data;
        end
    end
    assign bus.read_data = mem[bus.address[9:0]];

    typedef struct {
        logic        p0_req, p0_we;
        logic [31:0] p0_addr, p0_wdata;
        logic        p1_req, p1_we;
        logic [31:0] p1_addr, p1_wdata;
        logic        e_p0_gnt, e_p1_gnt, e_rd, e_wr;
        logic [31:0] e_addr, e_wdata;
        logic        e_p0_rvalid, e_p0_err;
        logic [31:0] e_p0_rdata;
        logic        e_p1_rvalid, e_p1_err;
        logic [31:0] e_p1_rdata;
    } vec_t;

    vec_t vt [NV];

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
        input logic g0, input logic g1, input logic rd, input logic wr,
        input logic [31:0] ea, input logic [31:0] ed,
        input logic v0, input logic er0, input logic [31:0] q0,
        input logic v1, input logic er1, input logic [31:0] q1);
        vec_t v;
        v.p0_req = r0; v.p0_we = w0; v.p0_addr = a0; v.p0_wdata = d0;
        v.p1_req = r1; v.p1_we = w1; v.p1_addr = a1; v.p1_wdata = d1;
        v.e_p0_gnt = g0; v.e_p1_gnt = g1; v.e_rd = rd; v.e_wr = wr;
        v.e_addr = ea; v.e_wdata = ed;
        v.e_p0_rvalid = v0; v.e_p0_err = er0; v.e_p0_rdata = q0;
        v.e_p1_rvalid = v1; v.e_p1_err = er1; v.e_p1_rdata = q1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic r1, input logic w1,
                         input logic [31:0] a1, input logic [31:0] d1);
        bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
        bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ab_req;
        logic [7:0] ab_gnt;

        rst = 1'b0;
        drive(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);

        // reset with both ports requesting reads
        edge_settle();
        edge_settle();
        chk("rst.p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
        chk("rst.p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
        chk("rst.p0_rdata",  bus.p0_rdata, 32'd0);
        chk("rst.p1_rdata",  bus.p1_rdata, 32'd0);
        chk("rst.p0_err",    32'(bus.p0_err), 32'd0);
        chk("rst.p1_err",    32'(bus.p1_err), 32'd0);
        chk("rst.wait_cnt",  32'(dut.wait_cnt), 32'd0);
        chk("rst.p0_gnt",    32'(bus.p0_gnt), 32'd1);
        chk("rst.p1_gnt",    32'(bus.p1_gnt), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel.p0_gnt", 32'(bus.p0_gnt), 32'd1);
        chk("rel.p1_gnt", 32'(bus.p1_gnt), 32'd0);
        edge_settle();
        chk("rel.p0_rvalid", 32'(bus.p0_rvalid), 32'd1);
        chk("rel.p0_rdata",  bus.p0_rdata, 32'd1);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        edge_settle();
        chk("idle.wait_cnt", 32'(dut.wait_cnt), 32'd0);

        //           p0 req/we/addr/wdata        p1 req/we/addr/wdata          g0 g1 rd wr addr   wdata         p0 rv/err/rdata        p1 rv/err/rdata
        vt[0]  = mk(1,1,32'd5,32'hDEADBEEF,    0,0,32'd0,32'd0,              1,0,0,1, 32'd5,   32'hDEADBEEF, 0,0,32'd1,             0,0,32'd0);
        vt[1]  = mk(1,0,32'd5,32'd0,           0,0,32'd0,32'd0,              1,0,1,0, 32'd5,   32'd0,        1,0,32'hDEADBEEF,      0,0,32'd0);
        vt[2]  = mk(0,0,32'd0,32'd0,           1,0,32'd3,32'd0,              0,1,1,0, 32'd3,   32'd0,        0,0,32'hDEADBEEF,      1,0,32'd3);
        vt[3]  = mk(0,0,32'd0,32'd0,           1,1,32'd1024,32'h1234,        0,1,0,0, 32'd1024,32'h1234,     0,0,32'hDEADBEEF,      0,1,32'd3);
        vt[4]  = mk(0,0,32'd0,32'd0,           1,0,32'd0,32'd0,              0,1,1,0, 32'd0,   32'd0,        0,0,32'hDEADBEEF,      1,0,32'd0);
        vt[5]  = mk(1,0,32'd2000,32'd0,        0,0,32'd0,32'd0,              1,0,0,0, 32'd2000,32'd0,        1,1,32'd0,             0,0,32'd0);
        vt[6]  = mk(0,0,32'd0,32'd0,           0,0,32'd0,32'd0,              0,0,0,0, 32'd0,   32'd0,        0,0,32'd0,             0,0,32'd0);
        vt[7]  = mk(1,0,32'd7,32'd0,           1,0,32'd9,32'd0,              1,0,1,0, 32'd7,   32'd0,        1,0,32'd7,             0,0,32'd0);
        vt[8]  = mk(0,0,32'd0,32'd0,           1,1,32'd1023,32'hCAFEF00D,    0,1,0,1, 32'd1023,32'hCAFEF00D, 0,0,32'd7,             0,0,32'd0);
        vt[9]  = mk(0,0,32'd0,32'd0,           1,0,32'd1023,32'd0,           0,1,1,0, 32'd1023,32'd0,        0,0,32'd7,             1,0,32'hCAFEF00D);
        vt[10] = mk(0,0,32'd0,32'd0,           0,0,32'd0,32'd0,              0,0,0,0, 32'd0,   32'd0,        0,0,32'd7,             0,0,32'hCAFEF00D);

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].p0_req, vt[i].p0_we, vt[i].p0_addr, vt[i].p0_wdata,
                  vt[i].p1_req, vt[i].p1_we, vt[i].p1_addr, vt[i].p1_wdata);
            @(negedge clk);
            chk($sformatf("v%0d.p0_gnt", i),     32'(bus.p0_gnt),    32'(vt[i].e_p0_gnt));
            chk($sformatf("v%0d.p1_gnt", i),     32'(bus.p1_gnt),    32'(vt[i].e_p1_gnt));
            chk($sformatf("v%0d.mem_read", i),   32'(bus.mem_read),  32'(vt[i].e_rd));
            chk($sformatf("v%0d.mem_write", i),  32'(bus.mem_write), 32'(vt[i].e_wr));
            chk($sformatf("v%0d.address", i),    bus.address,        vt[i].e_addr);
            chk($sformatf("v%0d.write_data", i), bus.write_data,     vt[i].e_wdata);
            edge_settle();
            chk($sformatf("v%0d.p0_rvalid", i),  32'(bus.p0_rvalid), 32'(vt[i].e_p0_rvalid));
            chk($sformatf("v%0d.p0_err", i),     32'(bus.p0_err),    32'(vt[i].e_p0_err));
            chk($sformatf("v%0d.p0_rdata", i),   bus.p0_rdata,       vt[i].e_p0_rdata);
            chk($sformatf("v%0d.p1_rvalid", i),  32'(bus.p1_rvalid), 32'(vt[i].e_p1_rvalid));
            chk($sformatf("v%0d.p1_err", i),     32'(bus.p1_err),    32'(vt[i].e_p1_err));
            chk($sformatf("v%0d.p1_rdata", i),   bus.p1_rdata,       vt[i].e_p1_rdata);
        end

        // continuous contention: 4:1 pattern
        drive(1'b1, 1'b0, 32'd10, 32'd0, 1'b1, 1'b0, 32'd11, 32'd0);
        for (int i = 0; i < 10; i++) begin
            logic exp1;
            exp1 = ((i % 5) == 4);
            @(negedge clk);
            chk($sformatf("cont%0d.p0_gnt", i), 32'(bus.p0_gnt), 32'(!exp1));
            chk($sformatf("cont%0d.p1_gnt", i), 32'(bus.p1_gnt), 32'(exp1));
            edge_settle();
            if (exp1) begin
                chk($sformatf("cont%0d.wait_cnt", i), 32'(dut.wait_cnt), 32'd0);
                chk($sformatf("cont%0d.p1_rdata", i), bus.p1_rdata, 32'd11);
            end else begin
                chk($sformatf("cont%0d.p0_rdata", i), bus.p0_rdata, 32'd10);
            end
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        edge_settle();

        // abandoned port-1 request under continuous port-0 traffic (bit i = cycle i)
        ab_req = 8'b1111_1011;
        ab_gnt = 8'b1000_0000;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'd20, 32'd0, ab_req[i], 1'b0, 32'd21, 32'd0);
            @(negedge clk);
            chk($sformatf("ab%0d.p1_gnt", i), 32'(bus.p1_gnt), 32'(ab_gnt[i]));
            edge_settle();
            if (i == 2) chk("ab2.wait_cnt", 32'(dut.wait_cnt), 32'd0);
        end

        // forced cycle with port-1 request withdrawn
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'd20, 32'd0, 1'b1, 1'b0, 32'd21, 32'd0);
            edge_settle();
        end
        chk("fd.wait_cnt_sat", 32'(dut.wait_cnt), 32'd4);
        drive(1'b1, 1'b0, 32'd20, 32'd0, 1'b0, 1'b0, 32'd21, 32'd0);
        @(negedge clk);
        chk("fd.p0_gnt", 32'(bus.p0_gnt), 32'd1);
        chk("fd.p1_gnt", 32'(bus.p1_gnt), 32'd0);
        edge_settle();
        chk("fd.wait_cnt", 32'(dut.wait_cnt), 32'd0);

        // reset asserted while a port-0 read response is pending
        drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 32'd6, 32'd0);
        @(negedge clk);
        chk("mr.p0_gnt", 32'(bus.p0_gnt), 32'd1);
        rst = 1'b0;
        #1;
        chk("mr.p0_rdata_async", bus.p0_rdata, 32'd0);
        edge_settle();
        chk("mr.p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
        chk("mr.wait_cnt",  32'(dut.wait_cnt), 32'd0);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        edge_settle();
        chk("mr.reissue_rvalid", 32'(bus.p0_rvalid), 32'd1);
        chk("mr.reissue_rdata",  bus.p0_rdata, 32'hDEADBEEF);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        edge_settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single-ported data memory between the pipeline MEM stage (port 0) and the memory loader/DMA path (port 1). Port 0 has fixed priority. A wait counter forces a grant to port 1 after MAX_WAIT consecutive denied cycles, so it cannot starve. The block drives the data memory's mem_read/mem_write/address/write_data and returns registered read data, tagged with the granted port, one cycle later.

## Interface
- DATA_W, 32, data width
- ADDR_W, 32, address width
- DEPTH, 1024, number of memory words; addresses >= DEPTH are out of range
- MAX_WAIT, 4, consecutive port-1 denials before a forced grant (legal range 1..15)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- p0_req, p1_req  in  1  access request, held until granted
- p0_we, p1_we  in  1  1 = write, 0 = read
- p0_addr, p1_addr  in  ADDR_W  word address
- p0_wdata, p1_wdata  in  DATA_W  write data
- p0_gnt, p1_gnt  out  1  combinational grant, same cycle as the request
- p0_rvalid, p1_rvalid  out  1  read data valid, registered
- p0_rdata, p1_rdata  out  DATA_W  read data, registered
- p0_err, p1_err  out  1  out-of-range access flag, registered one-cycle pulse
- mem_read, mem_write  out  1  data memory strobes
- address  out  ADDR_W  data memory address
- write_data  out  DATA_W  data memory write data
- read_data  in  DATA_W  data memory combinational read data

## Operation
- State: wait_cnt (4 bits) plus the registered response outputs.
- Forced mode is active when wait_cnt == MAX_WAIT.
- Grant rules:
  - Not forced: p0_gnt = p0_req; p1_gnt = p1_req && !p0_req.
  - Forced: p1_gnt = p1_req; p0_gnt = p0_req && !p1_req.
  - At most one grant per cycle.
- Memory drive for the winner:
  - address/write_data = winner's addr/wdata.
  - mem_write = gnt && we && in_range.
  - mem_read = gnt && !we && in_range.
  - in_range = addr < DEPTH.
  - With no grant, all memory outputs are 0.
- Out-of-range access:
  - Never forwarded to memory; writes are dropped.
  - A read returns 0 with rvalid = 1.
  - The matching pN_err pulses the next cycle.
- wait_cnt update:
  - Cleared when p1_gnt or !p1_req.
  - Incremented when p1_req && !p1_gnt and wait_cnt < MAX_WAIT.
  - Saturates at MAX_WAIT.
- Response registers, per port, each cycle:
  - pN_rvalid <= pN_gnt && !pN_we.
  - pN_rdata <= in_range ? read_data : 0, loaded only when the granted access is a read; otherwise held.
  - pN_err <= pN_gnt && !in_range.
- A write is complete at the clock edge ending its grant cycle. A read in the next cycle to the same address returns the new data.

## Timing
- Reset (rst = 0, asynchronous):
  - wait_cnt = 0; all rvalid, rdata and err = 0.
  - Grant and memory outputs follow the combinational rules with wait_cnt = 0, so during reset p0 has priority.
  - Writes from the memory outputs are not suppressed by the arbiter.
- Reset asserted with a read response pending: the response is lost and rvalid stays 0. The requester re-issues after reset.
- Grant latency is 0 cycles. Read data latency is 1 cycle after the grant cycle.
- Back-to-back grants to the same port are allowed every cycle. The response stream for a port is in order, one per granted read.
- Requesters must hold req, we, addr and wdata stable until gnt. Deasserting req before gnt is legal: the access is abandoned and wait_cnt clears if it was port 1.
- Both ports requesting continuously: port 0 is granted MAX_WAIT cycles, then port 1 is granted 1 cycle; the pattern repeats (MAX_WAIT:1).
- Forced cycle with p1_req dropped: port 0 wins and wait_cnt clears.
- MAX_WAIT outside 1..15 is illegal and must be flagged by an elaboration-time check.

## Test plan
- Reset: rst = 0 with p0 and p1 read requests active -> all rvalid, rdata and err = 0. After release, first p0_gnt = 1 with p1_gnt = 0.
- Single-port traffic:
  - p0 writes 0xDEADBEEF to address 5, then reads address 5 -> p0_rvalid = 1 one cycle after the read grant, p0_rdata = 0xDEADBEEF, p1 outputs idle.
  - p1 alone reads address 3 of the preloaded memory -> p1_rdata = 3.
- Contention with MAX_WAIT = 4: p0_req and p1_req held high for 10 cycles -> grant sequence p0,p0,p0,p0,p1,p0,p0,p0,p0,p1; wait_cnt returns to 0 after each p1 grant.
- Out of range: p1 writes address 1024 -> mem_write = 0, p1_err = 1 for one cycle, memory unchanged. p0 reads address 2000 -> p0_rdata = 0, p0_rvalid = 1, p0_err = 1.
- Reset mid-operation: p0 read granted, rst = 0 asserted before the next edge -> p0_rvalid stays 0 and wait_cnt = 0. After release, the re-issued read returns the correct data.
- Abandoned request: p1_req high for 2 denied cycles, then low for 1 cycle, then high again under continuous p0 -> wait_cnt restarts from 0 and p1 is granted only after 4 further denied cycles.
